// File: rtl/counter_arb_if.sv
// Requester-side bundle for the shared counter-increment arbiter.
// The arbiter takes the slave view; the driving logic takes the master view.
interface counter_arb_if #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int W   = 12
);
  logic [N-1:0]   req;
  logic           hold;
  logic [W-1:0]   limit;
  logic [N-1:0]   ack;
  logic [IDW-1:0] gnt_id;
  logic           inc;
  logic [W-1:0]   count_s;
  logic           at_limit;

  modport master (
    output req, hold, limit,
    input  ack, gnt_id, inc, count_s, at_limit
  );

  modport slave (
    input  req, hold, limit,
    output ack, gnt_id, inc, count_s, at_limit
  );
endinterface

// File: rtl/counter_arb.sv
// Round-robin arbiter feeding one counter increment port.
// Keeps a shadow increment total and stops granting at a limit.
module counter_arb #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int W   = 12
) (
  input  logic          clock,
  input  logic          reset,
  counter_arb_if.slave  bus
);

  logic [N-1:0]   r_ack;
  logic           r_inc;
  logic [IDW-1:0] r_gid;
  logic [IDW-1:0] r_ptr;
  logic [W-1:0]   r_cnt;

  logic [N-1:0]   w_elig;
  logic [N-1:0]   w_onehot;
  logic [IDW:0]   w_idx;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_ptr_nxt;
  logic           w_found;
  logic           w_at_limit;
  logic           w_grant;

  assign w_at_limit = (r_cnt == bus.limit);

  // Search upward from r_ptr; the requester acked this cycle sits out.
  always_comb begin
    w_elig  = bus.req & ~r_ack;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(N))
        w_idx = w_idx - (IDW+1)'(N);
      if (!w_found && w_elig[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDW-1:0];
      end
    end
  end

  assign w_grant   = w_found & ~bus.hold & ~w_at_limit;
  assign w_onehot  = {{(N-1){1'b0}}, 1'b1} << w_win;
  assign w_ptr_nxt = (w_win == IDW'(N-1)) ? '0
                                          : w_win + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ack <= '0;
      r_inc <= 1'b0;
      r_gid <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      r_ack <= w_grant ? w_onehot : '0;
      r_inc <= w_grant;
      if (w_grant) begin
        r_gid <= w_win;
        r_ptr <= w_ptr_nxt;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.ack      = r_ack;
  assign bus.inc      = r_inc;
  assign bus.gnt_id   = r_gid;
  assign bus.count_s  = r_cnt;
  assign bus.at_limit = w_at_limit;

endmodule
